// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU operation encodings and the control word
// passed from decode to execute.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_t;

   typedef struct packed {
      logic    reg_dest;
      logic    branch;
      logic    branch_ne;
      logic    mem_read;
      logic    mem_to_reg;
      logic    mem_write;
      logic    alu_src;
      logic    reg_write;
      alu_op_t alu_op;
      logic    illegal;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
      ctrl_t c;
      c = '0;
      case (opcode)
         OP_RTYPE: begin
            c.reg_dest  = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALU_FUNCT;
         end
         OP_LW: begin
            c.alu_src    = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         OP_SW: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         OP_BEQ: begin
            c.branch = 1'b1;
            c.alu_op = ALU_SUB;
         end
         OP_BNE: begin
            c.branch    = 1'b1;
            c.branch_ne = 1'b1;
            c.alu_op    = ALU_SUB;
         end
         OP_ADDI: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
         end
         OP_HALT: ;  // never emitted as a bundle
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/reg_file.sv
// Register file with two combinational read ports, one write port and a
// same-cycle write-back bypass. Entry 0 is constant zero and has no storage.
module reg_file #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [4:0]        i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [4:0]        i_rs_addr,
   input  logic [4:0]        i_rt_addr,
   output logic [DATA_W-1:0] o_rs_val,
   output logic [DATA_W-1:0] o_rt_val
);

   logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];

   // NOTE: the array is small and must read zero after reset, so every entry is
   // reset explicitly; a larger RAM-style memory would normally not be reset.
   // NOTE: non-blocking assignments here so all entries update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++)
            if (i_wr_en && i_wr_addr == 5'(i)) r_regs[i] <= i_wr_data;
      end
   end

   // NOTE: outputs get a default before the loop so no latch is inferred.
   // Indices 0 and >= NUM_REGS never match the loop and fall through to zero.
   always_comb begin
      o_rs_val = '0;
      o_rt_val = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (i_rs_addr == 5'(i))
            o_rs_val = (i_wr_en && i_wr_addr == 5'(i)) ? i_wr_data : r_regs[i];
         if (i_rt_addr == 5'(i))
            o_rt_val = (i_wr_en && i_wr_addr == 5'(i)) ? i_wr_data : r_regs[i];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: field split, control decode, operand read with bypass,
// single-entry valid/ready output register, load-use stall and sticky halt.
module decode_stage
   import mips_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rs_val,
   output logic [DATA_W-1:0] out_rt_val,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_dest,
   output logic [DATA_W-1:0] out_imm,
   output logic [4:0]        out_shamt,
   output logic [5:0]        out_funct,
   output logic              out_reg_dest,
   output logic              out_branch,
   output logic              out_branch_ne,
   output logic              out_mem_read,
   output logic              out_mem_to_reg,
   output logic              out_mem_write,
   output logic              out_alu_src,
   output logic              out_reg_write,
   output logic [1:0]        out_alu_op,
   output logic              out_illegal,
   output logic              end_program
);

   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   state_t            r_state, w_state_next;
   logic              r_valid;
   ctrl_t             r_ctrl;
   logic [DATA_W-1:0] r_rs_val, r_rt_val, r_imm;
   logic [4:0]        r_rs, r_rt, r_dest, r_shamt;
   logic [5:0]        r_funct;

   ctrl_t             w_ctrl;
   logic [DATA_W-1:0] w_rs_val, w_rt_val;
   logic [4:0]        w_rs, w_rt, w_dest;
   logic              w_is_halt, w_hazard, w_accept;

   assign w_rs      = in_instr[25:21];
   assign w_rt      = in_instr[20:16];
   assign w_ctrl    = decode_ctrl(in_instr[31:26]);
   assign w_is_halt = (in_instr[31:26] == OP_HALT);
   assign w_dest    = w_ctrl.reg_dest ? in_instr[15:11] : w_rt;

   // Consumer right behind a load must wait until the load has left this stage.
   assign w_hazard = r_valid && r_ctrl.mem_read && (r_dest != 5'd0) &&
                     (r_dest == w_rs || r_dest == w_rt);
   assign in_ready = (r_state == ST_RUN) && !w_hazard && (!r_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_reg_file (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (wb_en),
      .i_wr_addr (wb_addr),
      .i_wr_data (wb_data),
      .i_rs_addr (w_rs),
      .i_rt_addr (w_rt),
      .o_rs_val  (w_rs_val),
      .o_rt_val  (w_rt_val)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (r_state == ST_RUN && w_accept && w_is_halt) w_state_next = ST_HALTED;
   end

   // An accepted halt takes the drain branch, so it never becomes a bundle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_ctrl   <= '0;
         r_rs_val <= '0;
         r_rt_val <= '0;
         r_imm    <= '0;
         r_rs     <= '0;
         r_rt     <= '0;
         r_dest   <= '0;
         r_shamt  <= '0;
         r_funct  <= '0;
      end else if (w_accept && !w_is_halt) begin
         r_valid  <= 1'b1;
         r_ctrl   <= w_ctrl;
         r_rs_val <= w_rs_val;
         r_rt_val <= w_rt_val;
         r_imm    <= DATA_W'($signed(in_instr[15:0]));
         r_rs     <= w_rs;
         r_rt     <= w_rt;
         r_dest   <= w_dest;
         r_shamt  <= in_instr[10:6];
         r_funct  <= in_instr[5:0];
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid      = r_valid;
   assign out_rs_val     = r_rs_val;
   assign out_rt_val     = r_rt_val;
   assign out_rs         = r_rs;
   assign out_rt         = r_rt;
   assign out_dest       = r_dest;
   assign out_imm        = r_imm;
   assign out_shamt      = r_shamt;
   assign out_funct      = r_funct;
   assign out_reg_dest   = r_ctrl.reg_dest;
   assign out_branch     = r_ctrl.branch;
   assign out_branch_ne  = r_ctrl.branch_ne;
   assign out_mem_read   = r_ctrl.mem_read;
   assign out_mem_to_reg = r_ctrl.mem_to_reg;
   assign out_mem_write  = r_ctrl.mem_write;
   assign out_alu_src    = r_ctrl.alu_src;
   assign out_reg_write  = r_ctrl.reg_write;
   assign out_alu_op     = r_ctrl.alu_op;
   assign out_illegal    = r_ctrl.illegal;
   assign end_program    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of single-instruction vectors plus
// directed sequences for load-use, hold, halt and asynchronous reset.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_instr;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid, out_ready;
   logic [31:0] out_rs_val, out_rt_val, out_imm;
   logic [4:0]  out_rs, out_rt, out_dest, out_shamt;
   logic [5:0]  out_funct;
   logic        out_reg_dest, out_branch, out_branch_ne, out_mem_read;
   logic        out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write;
   logic [1:0]  out_alu_op;
   logic        out_illegal, end_program;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
      .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest),
      .out_imm(out_imm), .out_shamt(out_shamt), .out_funct(out_funct),
      .out_reg_dest(out_reg_dest), .out_branch(out_branch),
      .out_branch_ne(out_branch_ne), .out_mem_read(out_mem_read),
      .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write),
      .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
      .out_alu_op(out_alu_op), .out_illegal(out_illegal),
      .end_program(end_program)
   );

   // {reg_dest, branch, branch_ne, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
   wire [7:0] ctrl_bits = {out_reg_dest, out_branch, out_branch_ne, out_mem_read,
                           out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write};

   typedef struct {
      logic [31:0] instr;
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [7:0]  ctrl;
      logic [1:0]  alu_op;
      logic        illegal;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
      wb_en = 1'b1; wb_addr = addr; wb_data = data;
      tick();
      wb_en = 1'b0;
   endtask

   initial begin
      vec_t v;
      //                instr       wb  wa     wd            rs_val        rt_val        imm           dest shamt funct  ctrl          alu    ill
      vecs[0]  = '{32'h8E120000, 1'b0, 5'd0,  32'h0,     32'h100,    32'h0,      32'h0,      5'd18, 5'd0, 6'h00, 8'b00011011, 2'b00, 1'b0}; // lw $18,0($16)
      vecs[1]  = '{32'h02441820, 1'b0, 5'd0,  32'h0,     32'h0,      32'h44,     32'h1820,   5'd3,  5'd0, 6'h20, 8'b10000001, 2'b10, 1'b0}; // add $3,$18,$4
      vecs[2]  = '{32'h000440C0, 1'b0, 5'd0,  32'h0,     32'h0,      32'h44,     32'h40C0,   5'd8,  5'd3, 6'h00, 8'b10000001, 2'b10, 1'b0}; // sll $8,$4,3
      vecs[3]  = '{32'h1204FFFF, 1'b0, 5'd0,  32'h0,     32'h100,    32'h44,     32'hFFFFFFFF, 5'd4, 5'd31, 6'h3F, 8'b01000000, 2'b01, 1'b0}; // beq
      vecs[4]  = '{32'h1604FFFF, 1'b0, 5'd0,  32'h0,     32'h100,    32'h44,     32'hFFFFFFFF, 5'd4, 5'd31, 6'h3F, 8'b01100000, 2'b01, 1'b0}; // bne
      vecs[5]  = '{32'hAC890008, 1'b0, 5'd0,  32'h0,     32'h44,     32'h900,    32'h8,      5'd9,  5'd0, 6'h08, 8'b00000110, 2'b00, 1'b0}; // sw $9,8($4)
      vecs[6]  = '{32'h2207FFFE, 1'b0, 5'd0,  32'h0,     32'h100,    32'h0,      32'hFFFFFFFE, 5'd7, 5'd31, 6'h3E, 8'b00000011, 2'b00, 1'b0}; // addi $7,$16,-2
      vecs[7]  = '{32'h00A00820, 1'b1, 5'd5,  32'hDEAD,  32'hDEAD,   32'h0,      32'h0820,   5'd1,  5'd0, 6'h20, 8'b10000001, 2'b10, 1'b0}; // add $1,$5,$0 + bypass
      vecs[8]  = '{32'h00001020, 1'b1, 5'd0,  32'hBEEF,  32'h0,      32'h0,      32'h1020,   5'd2,  5'd0, 6'h20, 8'b10000001, 2'b10, 1'b0}; // write to r0 ignored
      vecs[9]  = '{32'h40A50001, 1'b0, 5'd0,  32'h0,     32'hDEAD,   32'hDEAD,   32'h1,      5'd5,  5'd0, 6'h01, 8'b00000000, 2'b00, 1'b1}; // illegal opcode
      vecs[10] = '{32'hAC000000, 1'b0, 5'd0,  32'h0,     32'h0,      32'h0,      32'h0,      5'd0,  5'd0, 6'h00, 8'b00000110, 2'b00, 1'b0}; // sw $0,0($0)

      rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_end_program", end_program, 0);
      check("reset_fields", {out_rs_val, out_imm}, 0);
      check("reset_ctrl", {ctrl_bits, out_alu_op, out_illegal}, 0);
      tick();

      wb_write(5'd16, 32'h100);
      wb_write(5'd4,  32'h44);
      wb_write(5'd9,  32'h900);

      for (int i = 0; i < 11; i++) begin
         v = vecs[i];
         in_valid = 1'b1; in_instr = v.instr;
         wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
         #1;
         check($sformatf("v%0d_in_ready", i), in_ready, 1);
         tick();
         in_valid = 1'b0; wb_en = 1'b0;
         check($sformatf("v%0d_out_valid", i), out_valid, 1);
         check($sformatf("v%0d_rs_val", i), out_rs_val, v.rs_val);
         check($sformatf("v%0d_rt_val", i), out_rt_val, v.rt_val);
         check($sformatf("v%0d_rs_rt", i), {out_rs, out_rt}, {v.instr[25:21], v.instr[20:16]});
         check($sformatf("v%0d_dest", i), out_dest, v.dest);
         check($sformatf("v%0d_imm", i), out_imm, v.imm);
         check($sformatf("v%0d_shamt_funct", i), {out_shamt, out_funct}, {v.shamt, v.funct});
         check($sformatf("v%0d_ctrl", i), ctrl_bits, v.ctrl);
         check($sformatf("v%0d_alu_op", i), out_alu_op, v.alu_op);
         check($sformatf("v%0d_illegal", i), out_illegal, v.illegal);
         tick();
      end

      // Load-use: lw $18 then add $3,$18,$4 back to back.
      in_valid = 1'b1; in_instr = 32'h8E120000; out_ready = 1'b1;
      tick();
      check("lu_lw_valid", {out_valid, out_mem_read}, 2'b11);
      in_instr = 32'h02441820;
      #1;
      check("lu_stall_ready", in_ready, 0);
      tick();
      check("lu_bubble_valid", out_valid, 0);
      check("lu_bubble_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("lu_add_valid", out_valid, 1);
      check("lu_add_dest", out_dest, 5'd3);
      check("lu_add_alu_op", out_alu_op, 2'b10);
      check("lu_add_rt_val", out_rt_val, 32'h44);
      tick();

      // Hold: beq held for 3 cycles while r16 is overwritten underneath it.
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h1204FFFF;
      tick();
      in_instr = 32'hAC890008;
      wb_en = 1'b1; wb_addr = 5'd16; wb_data = 32'h555;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("hold%0d_in_ready", c), in_ready, 0);
         tick();
         wb_en = 1'b0;
         check($sformatf("hold%0d_valid", c), out_valid, 1);
         check($sformatf("hold%0d_bundle", c), {out_imm, out_branch, out_alu_op}, {32'hFFFFFFFF, 1'b1, 2'b01});
         check($sformatf("hold%0d_rs_val", c), out_rs_val, 32'h100);
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("release_valid", out_valid, 1);
      check("release_sw", {out_mem_write, out_branch, out_imm}, {1'b1, 1'b0, 32'h8});
      check("release_rs_val", out_rs_val, 32'h44);
      tick();
      check("release_drained", out_valid, 0);

      // Halt: no bundle, in_ready stays low.
      in_valid = 1'b1; in_instr = 32'hFC000000;
      #1;
      check("halt_accept_ready", in_ready, 1);
      tick();
      check("halt_end_program", end_program, 1);
      check("halt_no_valid", out_valid, 0);
      in_instr = 32'h02441820;
      for (int c = 0; c < 2; c++) begin
         check($sformatf("halted%0d_ready", c), in_ready, 0);
         tick();
         check($sformatf("halted%0d_valid", c), out_valid, 0);
         check($sformatf("halted%0d_sticky", c), end_program, 1);
      end

      // Asynchronous reset away from the clock edge clears the halt.
      #2 rst = 1'b1; in_valid = 1'b0;
      #1;
      check("arst_end_program", end_program, 0);
      check("arst_out_valid", out_valid, 0);
      #3 rst = 1'b0;
      tick();
      check("arst_in_ready", in_ready, 1);

      // Registers cleared by reset; then drop an in-flight bundle with reset.
      in_valid = 1'b1; in_instr = 32'h2207FFFE;
      tick();
      in_valid = 1'b0;
      check("post_rst_valid", out_valid, 1);
      check("post_rst_r16", out_rs_val, 32'h0);
      check("post_rst_imm", out_imm, 32'hFFFFFFFE);
      #2 rst = 1'b1;
      #1;
      check("drop_valid", out_valid, 0);
      check("drop_fields", {out_imm, out_reg_write, out_alu_src}, 0);
      #3 rst = 1'b0;
      tick();
      check("drop_in_ready", in_ready, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined instruction-decode stage for the MIPS core. It sits between fetch and execute and splits each 32-bit instruction into fields. It generates the control word and reads operands from an integrated register file that has a write-back bypass. It connects to both neighbours through valid/ready handshakes and inserts a bubble on load-use hazards. Programs stop on the halt opcode.

## Interface
- DATA_W, 32, register/operand/immediate width (≥16)
- NUM_REGS, 32, register count (≤32; register 0 hard-wired to zero)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents in_instr
- in_ready  out  1  stage accepts in_instr this cycle
- in_instr  in  32  instruction word
- wb_en  in  1  write-back enable
- wb_addr  in  5  write-back register
- wb_data  in  DATA_W  write-back value
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_rs_val, out_rt_val  out  DATA_W  operand values
- out_rs, out_rt, out_dest  out  5  source/destination indices
- out_imm  out  DATA_W  sign-extended instr[15:0]
- out_shamt  out  5; out_funct  out  6
- out_reg_dest, out_branch, out_branch_ne, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write  out  1 each  control
- out_alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
- out_illegal  out  1  unrecognised opcode
- end_program  out  1  sticky halt flag

## Operation
- Opcode decode:
  - R-type (000000): reg_dest=1, reg_write=1, alu_op=10.
  - lw (100011): alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00.
  - sw (101011): alu_src=1, mem_write=1, alu_op=00.
  - beq (000100): branch=1, alu_op=01.
  - bne (000101): branch=1, branch_ne=1, alu_op=01.
  - addi (001000): alu_src=1, reg_write=1, alu_op=00.
  - All unlisted control bits are 0. No X values are ever driven.
- Halt (111111):
  - Sets end_program.
  - Produces no output bundle.
  - in_ready then stays 0 until rst.
- Any other opcode: bundle is emitted with all control bits 0 and out_illegal=1.
- out_dest = reg_dest ? instr[15:11] : instr[20:16]. out_imm is the sign extension of instr[15:0] to DATA_W.
- Register file:
  - Reads are combinational.
  - Index 0 always reads 0. Writes to index 0 are ignored.
  - Indices ≥ NUM_REGS read 0 and ignore writes.
- Bypass: when wb_en=1 and wb_addr equals a nonzero source index in the same cycle, the operand takes wb_data.
- Load-use hazard condition: out_valid, out_mem_read, out_dest≠0, and out_dest equal to in_instr[25:21] or in_instr[20:16]. While it holds, in_ready=0.
- Output register:
  - Single-entry.
  - in_ready = !end_program && !hazard && (!out_valid || out_ready).

## Timing
- Reset: every output register, every register-file entry and end_program are cleared to 0. in_ready becomes 1 as soon as rst deasserts.
- Latency: an instruction accepted at edge N is visible with out_valid=1 after edge N; latency is one cycle.
- Throughput: one instruction per cycle when out_ready=1 and no hazard is present.
- Hold: while out_valid=1 and out_ready=0, all out_* signals are stable and in_ready=0.
- Load-use: a consumer directly after a lw gets exactly one bubble cycle (out_valid=0) before it is accepted.
- Accept and drain in the same cycle: the register is replaced; out_valid stays 1.
- Write-back to the register file commits at the clock edge and is visible through the bypass in the same cycle.
- Operands are captured into the output register at accept time and are not refreshed while held.
- Reset asserted mid-operation: the bundle in flight is dropped immediately (asynchronous) and the halt is cleared.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_HALT)
  - alu_op encodings
  - the control-word typedef, shared with execute.
- Sub-module reg_file:
  - NUM_REGS×DATA_W storage
  - two read ports, one write port
  - async reset
  - internal bypass
- Decode and control logic plus the handshake live in decode_stage.

## Test plan
- Write-back 0x100 to r16, then send 0x8E120000 (lw $18,0($16)). Required: out_rs_val=0x100, out_dest=18, mem_read=1, mem_to_reg=1, alu_src=1, mem_write=0.
- Send lw $18 then add $3,$18,$4 (0x02441820) back to back with out_ready=1. Required: in_ready=0 for one cycle, one bubble, then the add emits with out_dest=3 and alu_op=10.
- Send beq with offset 0xFFFF. Required: out_imm=0xFFFFFFFF and branch=1, alu_op=01. Then bne. Required: branch_ne=1.
- Hold out_ready=0 for 3 cycles with a valid bundle. Required: outputs unchanged and in_ready=0. Then release. Required: next instruction emits one cycle later.
- Same-cycle wb_en to r5 with 0xDEAD while decoding an instruction with rs=5. Required: out_rs_val=0xDEAD. A write to r0 must leave reads at 0.
- Send 0xFC000000. Required: end_program=1, no out_valid, in_ready held 0. Pulse rst mid-stream. Required: all outputs 0, registers cleared, in_ready=1.
